// File: rtl/adc_pkg.sv
// Shared definitions for the ADC sample averaging path: frame layout and FSM states.
package adc_pkg;

  localparam int unsigned ADC_FRAME_W = 16;
  localparam int unsigned ADC_DATA_W  = 12;
  localparam int unsigned ADC_PAD_W   = 4;

  typedef enum logic {
    ST_ACUM = 1'b0,
    ST_CALC = 1'b1
  } adc_state_t;

endpackage

// File: rtl/adc_avg_out_reg.sv
// Output holding register for the averaged sample: valid/ready hold with sticky overrun.
module adc_avg_out_reg
  import adc_pkg::*;
#(
  parameter int unsigned DATA_W = ADC_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_clear,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  output logic              o_overrun
);

  logic w_accept;
  assign w_accept = o_valid & i_ready;

  // Hold data until accepted; a load on an unaccepted result overwrites it and flags overrun.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      o_data    <= '0;
      o_valid   <= 1'b0;
      o_overrun <= 1'b0;
    end else if (i_clear) begin
      o_valid   <= 1'b0;
      o_overrun <= 1'b0;
    end else if (i_load) begin
      o_data  <= i_data;
      o_valid <= 1'b1;
      if (o_valid && !w_accept) begin
        o_overrun <= 1'b1;
      end
    end else if (w_accept) begin
      o_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/adc_sample_averager.sv
// Validates ADC frames, averages 2**LOG2_N good samples and presents the result via valid/ready.
// Optional ADC_AVG_MINMAX_EN adds win_min/win_max of the last completed window.
module adc_sample_averager
  import adc_pkg::*;
#(
  parameter int unsigned DATA_W = ADC_DATA_W,
  parameter int unsigned LOG2_N = 2,
  parameter int unsigned ROUND  = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   rx_done_tick,
  input  logic [ADC_FRAME_W-1:0] b_reg,
  input  logic                   clear,
  output logic [DATA_W-1:0]      avg_data,
  output logic                   avg_valid,
  input  logic                   avg_ready,
  output logic                   frame_err,
  output logic [7:0]             err_count,
  output logic                   overrun
`ifdef ADC_AVG_MINMAX_EN
  ,
  output logic [DATA_W-1:0]      win_min,
  output logic [DATA_W-1:0]      win_max
`endif
);

  localparam int unsigned ACC_W = DATA_W + LOG2_N;
  localparam logic [ACC_W:0] RND = (ROUND != 0) ? ((ACC_W+1)'(1) << (LOG2_N - 1)) : '0;

  adc_state_t        r_state;
  adc_state_t        w_state_nxt;
  logic [ACC_W-1:0]  r_acc;
  logic [ACC_W-1:0]  r_sum_hold;
  logic [LOG2_N-1:0] r_cnt;
  logic              r_frame_err;
  logic [7:0]        r_err_count;

  logic              w_pad_ok;
  logic              w_good;
  logic              w_bad;
  logic              w_last;
  logic              w_load;
  logic [DATA_W-1:0] w_sample;
  logic [ACC_W-1:0]  w_sum;
  logic [DATA_W-1:0] w_result;

  assign w_pad_ok = (b_reg[ADC_FRAME_W-1 -: ADC_PAD_W] == '0);
  assign w_good   = rx_done_tick & w_pad_ok & ~clear;
  assign w_bad    = rx_done_tick & ~w_pad_ok & ~clear;
  assign w_sample = b_reg[DATA_W-1:0];
  assign w_last   = &r_cnt;
  assign w_sum    = r_acc + ACC_W'(w_sample);
  // One extra bit for the rounding add, then drop the window bits.
  assign w_result = DATA_W'(({1'b0, r_sum_hold} + RND) >> LOG2_N);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_ACUM;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and result load strobe; clear overrides everything.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    unique case (r_state)
      ST_ACUM: if (w_good && w_last) w_state_nxt = ST_CALC;
      ST_CALC: begin
        w_state_nxt = ST_ACUM;
        w_load      = 1'b1;
      end
      default: w_state_nxt = ST_ACUM;
    endcase
    if (clear) begin
      w_state_nxt = ST_ACUM;
      w_load      = 1'b0;
    end
  end

  // Accumulate good samples; the window sum is handed off so a tick during ST_CALC starts the next window.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_acc      <= '0;
      r_cnt      <= '0;
      r_sum_hold <= '0;
    end else if (clear) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (w_good) begin
      if (w_last) begin
        r_sum_hold <= w_sum;
        r_acc      <= '0;
        r_cnt      <= '0;
      end else begin
        r_acc <= w_sum;
        r_cnt <= r_cnt + LOG2_N'(1);
      end
    end
  end

  // Rejected-frame pulse and saturating error counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_frame_err <= 1'b0;
      r_err_count <= '0;
    end else begin
      r_frame_err <= w_bad;
      if (w_bad && (r_err_count != '1)) begin
        r_err_count <= r_err_count + 8'd1;
      end
    end
  end

  assign frame_err = r_frame_err;
  assign err_count = r_err_count;

  adc_avg_out_reg #(
    .DATA_W (DATA_W)
  ) u_out_reg (
    .clk       (clk),
    .reset     (reset),
    .i_clear   (clear),
    .i_load    (w_load),
    .i_data    (w_result),
    .i_ready   (avg_ready),
    .o_data    (avg_data),
    .o_valid   (avg_valid),
    .o_overrun (overrun)
  );

`ifdef ADC_AVG_MINMAX_EN
  logic [DATA_W-1:0] r_cur_min;
  logic [DATA_W-1:0] r_cur_max;
  logic [DATA_W-1:0] r_hold_min;
  logic [DATA_W-1:0] r_hold_max;
  logic [DATA_W-1:0] r_win_min;
  logic [DATA_W-1:0] r_win_max;
  logic [DATA_W-1:0] w_new_min;
  logic [DATA_W-1:0] w_new_max;

  // First sample of a window seeds both extremes.
  assign w_new_min = ((r_cnt == '0) || (w_sample < r_cur_min)) ? w_sample : r_cur_min;
  assign w_new_max = ((r_cnt == '0) || (w_sample > r_cur_max)) ? w_sample : r_cur_max;

  // Track window extremes and publish them alongside the average.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cur_min  <= '0;
      r_cur_max  <= '0;
      r_hold_min <= '0;
      r_hold_max <= '0;
      r_win_min  <= '0;
      r_win_max  <= '0;
    end else if (clear) begin
      r_cur_min <= '0;
      r_cur_max <= '0;
      r_win_min <= '0;
      r_win_max <= '0;
    end else begin
      if (w_good) begin
        if (w_last) begin
          r_hold_min <= w_new_min;
          r_hold_max <= w_new_max;
        end else begin
          r_cur_min <= w_new_min;
          r_cur_max <= w_new_max;
        end
      end
      if (w_load) begin
        r_win_min <= r_hold_min;
        r_win_max <= r_hold_max;
      end
    end
  end

  assign win_min = r_win_min;
  assign win_max = r_win_max;
`endif

endmodule
